id_ex_operand_stage: RTL

- ID/EX pipeline register plus EX-stage operand selection for the 5-stage pipelined RISC core.
- Latches decoded operands and control from ID and exposes the registered rs/rt/rd fields to the forwarding unit.
- Consumes the forwarding unit's 2-bit select codes to build the ALU operands and the store data.
- Detects load-use hazards, stalls IF/ID and inserts bubbles. Branch flushes also insert bubbles.

---
 rtl/id_ex_operand_stage_if.sv | 40 ++++
 rtl/id_ex_operand_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side inputs, forwarding controls and EX-side outputs of the ID/EX operand stage.
// The master modport is the surrounding pipeline; the slave modport is the stage itself.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic              id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [3:0]        id_aluop;
  logic              flush;
  logic [1:0]        forward_rs, forward_rt;
  logic [DATA_W-1:0] exmem_result, memwb_result;

  logic              ex_valid;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic              ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [3:0]        ex_aluop;
  logic [DATA_W-1:0] alu_a, alu_b, ex_store_data;
  logic              stall;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_aluop,
           flush, forward_rs, forward_rt, exmem_result, memwb_result,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
           ex_memtoreg, ex_aluop, alu_a, alu_b, ex_store_data, stall, bubble_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_aluop,
           flush, forward_rs, forward_rt, exmem_result, memwb_result,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
           ex_memtoreg, ex_aluop, alu_a, alu_b, ex_store_data, stall, bubble_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion and EX-stage operand forwarding.
// Bubbles zero indices and data too, so the forwarding unit never matches on a dead slot.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  id_ex_operand_stage_if.slave bus
);
  logic              ex_valid_reg;
  logic [REG_W-1:0]  ex_rs_reg, ex_rt_reg, ex_rd_reg;
  logic [DATA_W-1:0] ex_rs_data_reg, ex_rt_data_reg, ex_imm_reg;
  logic              ex_regwrite_reg, ex_memread_reg, ex_memwrite_reg, ex_memtoreg_reg;
  logic              ex_alusrc_reg;
  logic [3:0]        ex_aluop_reg;
  logic [CNT_W-1:0]  bubble_count_reg;

  logic hazard, stall, load_bubble;

  assign hazard = ex_valid_reg & ex_memread_reg & (ex_rd_reg != '0) & bus.id_valid &
                  ((ex_rd_reg == bus.id_rs) | (ex_rd_reg == bus.id_rt));
  // A flush kills the ID instruction anyway, so it overrides the stall.
  assign stall       = hazard & ~bus.flush & ~rst;
  assign load_bubble = bus.flush | stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg     <= 1'b0;
      ex_rs_reg        <= '0;
      ex_rt_reg        <= '0;
      ex_rd_reg        <= '0;
      ex_rs_data_reg   <= '0;
      ex_rt_data_reg   <= '0;
      ex_imm_reg       <= '0;
      ex_regwrite_reg  <= 1'b0;
      ex_memread_reg   <= 1'b0;
      ex_memwrite_reg  <= 1'b0;
      ex_memtoreg_reg  <= 1'b0;
      ex_alusrc_reg    <= 1'b0;
      ex_aluop_reg     <= '0;
      bubble_count_reg <= '0;
    end else if (load_bubble) begin
      ex_valid_reg    <= 1'b0;
      ex_rs_reg       <= '0;
      ex_rt_reg       <= '0;
      ex_rd_reg       <= '0;
      ex_rs_data_reg  <= '0;
      ex_rt_data_reg  <= '0;
      ex_imm_reg      <= '0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_memwrite_reg <= 1'b0;
      ex_memtoreg_reg <= 1'b0;
      ex_alusrc_reg   <= 1'b0;
      ex_aluop_reg    <= '0;
      if (bubble_count_reg != '1)
        bubble_count_reg <= bubble_count_reg + 1'b1;
    end else begin
      ex_valid_reg    <= bus.id_valid;
      ex_rs_reg       <= bus.id_rs;
      ex_rt_reg       <= bus.id_rt;
      ex_rd_reg       <= bus.id_rd;
      ex_rs_data_reg  <= bus.id_rs_data;
      ex_rt_data_reg  <= bus.id_rt_data;
      ex_imm_reg      <= bus.id_imm;
      ex_regwrite_reg <= bus.id_regwrite;
      ex_memread_reg  <= bus.id_memread;
      ex_memwrite_reg <= bus.id_memwrite;
      ex_memtoreg_reg <= bus.id_memtoreg;
      ex_alusrc_reg   <= bus.id_alusrc;
      ex_aluop_reg    <= bus.id_aluop;
    end
  end

  // Lane 0 forwards rs, lane 1 forwards rt; x0 always reads the registered value.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [1:0]        sel;
      logic [REG_W-1:0]  idx;
      logic [DATA_W-1:0] reg_data;
      logic [DATA_W-1:0] val;

      assign sel      = (gi == 0) ? bus.forward_rs : bus.forward_rt;
      assign idx      = (gi == 0) ? ex_rs_reg : ex_rt_reg;
      assign reg_data = (gi == 0) ? ex_rs_data_reg : ex_rt_data_reg;

      always_comb begin
        val = reg_data;
        if (idx != '0) begin
          case (sel)
            2'b01:   val = bus.exmem_result;
            2'b10:   val = bus.memwb_result;
            default: val = reg_data;
          endcase
        end
      end
    end
  endgenerate

  assign bus.alu_a         = g_fwd[0].val;
  assign bus.alu_b         = ex_alusrc_reg ? ex_imm_reg : g_fwd[1].val;
  assign bus.ex_store_data = g_fwd[1].val;

  assign bus.ex_valid     = ex_valid_reg;
  assign bus.ex_rs        = ex_rs_reg;
  assign bus.ex_rt        = ex_rt_reg;
  assign bus.ex_rd        = ex_rd_reg;
  assign bus.ex_regwrite  = ex_regwrite_reg;
  assign bus.ex_memread   = ex_memread_reg;
  assign bus.ex_memwrite  = ex_memwrite_reg;
  assign bus.ex_memtoreg  = ex_memtoreg_reg;
  assign bus.ex_aluop     = ex_aluop_reg;
  assign bus.stall        = stall;
  assign bus.bubble_count = bubble_count_reg;
endmodule
